// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Steps the select of a downstream 4:1 mux through all four inputs, holds
//   each select for SETTLE cycles so the mux output can settle, and then
//   samples y into the matching bit of word_out. A scan can be cancelled
//   with abort. In that case the bits already captured stay in word_out.
//
//   Parameters:
//     SETTLE  cycles sel is held before y is sampled (1..15)
//     DESC    0: scan order 0,1,2,3   1: scan order 3,2,1,0
//
//   Optional build macro:
//     MUX_SCAN_PARITY_EN  adds a registered 'parity' output, the XOR of the
//                         four captured bits, updated on entry to DONE.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; sel keeps its last value
//   HOLD  | sel driven, settle counter running, one bit sampled per SETTLE
//   DONE  | single-cycle completion; done=1, start and abort ignored

module mux_scan_ctrl #(
  parameter int SETTLE = 1,
  parameter bit DESC   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       y,
  output logic [1:0] sel,
  output logic [3:0] word_out,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       busy,
  output logic       done
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       parity
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] FIRST_SEL   = DESC ? 2'd3 : 2'd0;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] settle_cnt;
  logic [1:0] bit_cnt;

`ifdef MUX_SCAN_PARITY_EN
  logic [3:0] word_next;

  // Word as it will look once the current sample lands, used for parity.
  always_comb begin
    word_next      = word_out;
    word_next[sel] = y;
  end
`endif

  // Scan sequencer: all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 2'd0;
      word_out   <= 4'd0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      settle_cnt <= 4'd0;
      bit_cnt    <= 2'd0;
`ifdef MUX_SCAN_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      bit_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sel        <= FIRST_SEL;
            settle_cnt <= 4'd0;
            bit_cnt    <= 2'd0;
            busy       <= 1'b1;
            state      <= HOLD;
          end
        end

        HOLD: begin
          if (abort) begin
            // Abort beats a coincident sample: nothing is captured.
            settle_cnt <= 4'd0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            word_out[sel] <= y;
            bit_out       <= y;
            bit_valid     <= 1'b1;
            settle_cnt    <= 4'd0;
            if (bit_cnt != 2'd3) begin
              // Never wraps: the fourth sample ends the scan instead.
              sel     <= DESC ? (sel - 2'd1) : (sel + 2'd1);
              bit_cnt <= bit_cnt + 2'd1;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
`ifdef MUX_SCAN_PARITY_EN
              parity <= ^word_next;
`endif
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE=1 ascending, SETTLE=3
// descending) driven by directed and random scans. Expected behaviour is
// derived per cycle from edge arithmetic relative to the start edge.

module tb_mux_scan_ctrl;

  localparam int S0 = 1;
  localparam int S1 = 3;

  logic       clk = 1'b0;
  logic       rst_r   [2];
  logic       start_r [2];
  logic       abort_r [2];
  logic [3:0] x_pat   [2];
  logic       y_w     [2];
  logic [1:0] sel_w   [2];
  logic [3:0] word_w  [2];
  logic       bit_w   [2];
  logic       bv_w    [2];
  logic       busy_w  [2];
  logic       done_w  [2];
`ifdef MUX_SCAN_PARITY_EN
  logic       par_w   [2];
  logic       m_par   [2];
`endif

  logic [3:0] m_word [2];
  logic       m_bit  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign y_w[0] = x_pat[0][sel_w[0]];
  assign y_w[1] = x_pat[1][sel_w[1]];

  mux_scan_ctrl #(.SETTLE(S0), .DESC(1'b0)) u_asc (
    .clk      (clk),
    .rst      (rst_r[0]),
    .start    (start_r[0]),
    .abort    (abort_r[0]),
    .y        (y_w[0]),
    .sel      (sel_w[0]),
    .word_out (word_w[0]),
    .bit_out  (bit_w[0]),
    .bit_valid(bv_w[0]),
    .busy     (busy_w[0]),
    .done     (done_w[0])
`ifdef MUX_SCAN_PARITY_EN
    ,
    .parity   (par_w[0])
`endif
  );

  mux_scan_ctrl #(.SETTLE(S1), .DESC(1'b1)) u_desc (
    .clk      (clk),
    .rst      (rst_r[1]),
    .start    (start_r[1]),
    .abort    (abort_r[1]),
    .y        (y_w[1]),
    .sel      (sel_w[1]),
    .word_out (word_w[1]),
    .bit_out  (bit_w[1]),
    .bit_valid(bv_w[1]),
    .busy     (busy_w[1]),
    .done     (done_w[1])
`ifdef MUX_SCAN_PARITY_EN
    ,
    .parity   (par_w[1])
`endif
  );

  function automatic int settle_of(input int d);
    return (d == 0) ? S0 : S1;
  endfunction

  // k-th index visited in a scan
  function automatic int ord(input int d, input int k);
    return (d == 0) ? k : 3 - k;
  endfunction

  task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input int d, input string tag);
    chk({tag, "_sel"}, d, 8'(sel_w[d]), 8'd0);
    chk({tag, "_word"}, d, 8'(word_w[d]), 8'd0);
    chk({tag, "_bit"}, d, 8'(bit_w[d]), 8'd0);
    chk({tag, "_bv"}, d, 8'(bv_w[d]), 8'd0);
    chk({tag, "_busy"}, d, 8'(busy_w[d]), 8'd0);
    chk({tag, "_done"}, d, 8'(done_w[d]), 8'd0);
`ifdef MUX_SCAN_PARITY_EN
    chk({tag, "_par"}, d, 8'(par_w[d]), 8'd0);
`endif
  endtask

  // One scan from IDLE. abort_at = edge number (start edge is 0) at which
  // abort is high; 0 means never. hold_start keeps start high through the
  // DONE edge to show it is ignored while busy and in DONE.
  task automatic run_scan(input int d, input logic [3:0] x, input int abort_at, input bit hold_start);
    int s, last, m, taken, kk;
    bit ab, exp_busy, exp_done, exp_bv;
    s    = settle_of(d);
    last = 4 * s;
    ab   = (abort_at >= 1) && (abort_at <= last);
    @(negedge clk);
    x_pat[d]   = x;
    start_r[d] = 1'b1;
    abort_r[d] = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= last + 2; n++) begin
      @(negedge clk);
      start_r[d] = hold_start && (n <= last + 1);
      abort_r[d] = (n == abort_at);
      @(posedge clk);
      #1;
      m     = (ab && n >= abort_at) ? abort_at - 1 : n;
      taken = m / s;
      if (taken > 4) taken = 4;
      kk       = (taken > 3) ? 3 : taken;
      exp_busy = ab ? (n < abort_at) : (n < last);
      exp_done = !ab && (n == last);
      exp_bv   = (n % s == 0) && (n / s >= 1) && (n / s <= 4) && !(ab && n >= abort_at);
      if (exp_bv) begin
        m_bit[d] = x[ord(d, n / s - 1)];
        m_word[d][ord(d, n / s - 1)] = x[ord(d, n / s - 1)];
      end
      chk("sel", d, 8'(sel_w[d]), 8'(ord(d, kk)));
      chk("busy", d, 8'(busy_w[d]), 8'(exp_busy));
      chk("done", d, 8'(done_w[d]), 8'(exp_done));
      chk("bit_valid", d, 8'(bv_w[d]), 8'(exp_bv));
      chk("bit_out", d, 8'(bit_w[d]), 8'(m_bit[d]));
      if (exp_done) begin
        chk("word_done", d, 8'(word_w[d]), 8'(x));
`ifdef MUX_SCAN_PARITY_EN
        m_par[d] = ^x;
`endif
      end
`ifdef MUX_SCAN_PARITY_EN
      chk("parity", d, 8'(par_w[d]), 8'(m_par[d]));
`endif
    end
    start_r[d] = 1'b0;
    abort_r[d] = 1'b0;
    chk("word_end", d, 8'(word_w[d]), 8'(m_word[d]));
  endtask

  // Start a scan and hit rst on the sampling edge of the second bit.
  task automatic reset_mid(input int d, input logic [3:0] x);
    int s;
    s = settle_of(d);
    @(negedge clk);
    x_pat[d]   = x;
    start_r[d] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 2 * s; n++) begin
      @(negedge clk);
      start_r[d] = 1'b0;
      rst_r[d]   = (n == 2 * s);
      @(posedge clk);
    end
    #1;
    m_word[d] = 4'd0;
    m_bit[d]  = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    m_par[d]  = 1'b0;
`endif
    chk_idle_zero(d, "rst_mid");
    @(negedge clk);
    rst_r[d] = 1'b0;
    for (int n = 0; n < 4 * s + 2; n++) begin
      @(posedge clk);
      #1;
      chk("rst_no_done", d, 8'(done_w[d]), 8'd0);
      chk("rst_no_bv", d, 8'(bv_w[d]), 8'd0);
      chk("rst_idle_busy", d, 8'(busy_w[d]), 8'd0);
    end
  endtask

  initial begin
    int s, ab;
    logic [3:0] xr;
    for (int d = 0; d < 2; d++) begin
      rst_r[d]   = 1'b1;
      start_r[d] = 1'b0;
      abort_r[d] = 1'b0;
      x_pat[d]   = 4'd0;
      m_word[d]  = 4'd0;
      m_bit[d]   = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      m_par[d]   = 1'b0;
`endif
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk_idle_zero(d, "reset");
    @(negedge clk);
    rst_r[0] = 1'b0;
    rst_r[1] = 1'b0;

    // abort while idle does nothing
    abort_r[0] = 1'b1;
    abort_r[1] = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("idle_abort_busy", d, 8'(busy_w[d]), 8'd0);
      chk("idle_abort_sel", d, 8'(sel_w[d]), 8'd0);
    end
    @(negedge clk);
    abort_r[0] = 1'b0;
    abort_r[1] = 1'b0;

    // directed reference scans
    run_scan(0, 4'b1010, 0, 1'b0);
    run_scan(1, 4'b0110, 0, 1'b0);

    // abort during the sel=2 hold (coincides with its sampling edge at SETTLE=1)
    run_scan(0, 4'b0000, 0, 1'b0);
    run_scan(0, 4'b1111, 3, 1'b0);
    chk("abort_word", 0, 8'(word_w[0]), 8'b0011);
    run_scan(1, 4'b0000, 0, 1'b0);
    run_scan(1, 4'b1111, 5, 1'b0);
    run_scan(1, 4'b1010, 6, 1'b0);

    // start held high during the whole scan and the DONE cycle
    run_scan(0, 4'b1100, 0, 1'b1);
    run_scan(1, 4'b0101, 0, 1'b1);

    // abort during DONE is ignored
    run_scan(0, 4'b0110, 4 * S0 + 1, 1'b0);
    run_scan(1, 4'b1001, 4 * S1 + 1, 1'b0);

    // parity reference patterns
    run_scan(0, 4'b0111, 0, 1'b0);
    run_scan(0, 4'b0011, 0, 1'b0);
    run_scan(1, 4'b0111, 0, 1'b0);
    run_scan(1, 4'b0011, 0, 1'b0);

    // random scans with random abort points
    for (int i = 0; i < 12; i++) begin
      for (int d = 0; d < 2; d++) begin
        s  = settle_of(d);
        xr = 4'($urandom_range(0, 15));
        ab = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 4 * s + 1));
        run_scan(d, xr, ab, 1'($urandom_range(0, 1)) && (ab == 0));
      end
    end

    // reset at the second sampling edge
    reset_mid(0, 4'b1111);
    reset_mid(1, 4'b1111);
    run_scan(0, 4'b1001, 0, 1'b0);
    run_scan(1, 4'b1001, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 1, range 1..15: clock cycles sel is held before y is sampled.
REQ-002 SHALL have parameter DESC, default 0: 0 scans sel 0,1,2,3; 1 scans sel 3,2,1,0.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  scan request, sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  cancel an active scan.
REQ-007 SHALL have port y  input  1  output of the downstream 4:1 mux, assumed combinational from sel.
REQ-008 SHALL have port sel  output  2  select driven to the 4:1 mux, registered.
REQ-009 SHALL have port word_out  output  4  captured word, bit i = y sampled while sel==i.
REQ-010 SHALL have port bit_out  output  1  most recently sampled y.
REQ-011 SHALL have port bit_valid  output  1  one-cycle strobe, bit_out updated this cycle.
REQ-012 SHALL have port busy  output  1  high while a scan is active.
REQ-013 SHALL have port done  output  1  one-cycle strobe, word_out complete.

Function
REQ-014 SHALL implement FSM states IDLE, HOLD, DONE.
REQ-015 IDLE: busy=0; start=1 at an edge loads sel with the first index (0, or 3 if DESC=1), clears the settle counter, clears the bit count, and enters HOLD.
REQ-016 HOLD: busy=1; the settle counter increments each edge; at the edge where the counter equals SETTLE-1, y is written to word_out[sel] and bit_out, bit_valid pulses high for the following cycle, and the counter clears.
REQ-017 The same sampling edge SHALL advance sel by +1 (DESC=0) or -1 (DESC=1) if fewer than 4 bits are taken; otherwise sel holds and the FSM enters DONE.
REQ-018 DONE: lasts exactly one cycle with done=1 and busy=0, then returns to IDLE; a start during DONE SHALL be ignored.
REQ-019 Latency: start edge to done-high cycle SHALL be exactly 4*SETTLE+1 cycles.
REQ-020 start while busy SHALL be ignored; no queuing.
REQ-021 abort=1 in HOLD SHALL return the FSM to IDLE at that edge with no sample, no bit_valid, and no done; word_out keeps the bits already written.
REQ-022 Simultaneous abort and sampling edge: abort SHALL win, and the bit SHALL NOT be captured.
REQ-023 abort in IDLE or DONE SHALL have no effect.
REQ-024 word_out bits not yet rewritten in a new scan SHALL retain their prior values; word_out SHALL be coherent only when done=1.
REQ-025 sel SHALL hold its last value in IDLE; sel SHALL NOT wrap (3->0 or 0->3) within one scan.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, sel=0, word_out=0, bit_out=0, bit_valid=0, busy=0, done=0, and clear the counters, regardless of state.
REQ-027 rst SHALL take priority over start and abort; a scan interrupted by rst SHALL produce no done.

Configuration
REQ-028 Macro MUX_SCAN_PARITY_EN defined: SHALL add output port parity (1 bit, registered), equal to the XOR of the four captured bits, updated on the edge entering DONE, reset to 0, and held otherwise.
REQ-029 Macro MUX_SCAN_PARITY_EN undefined: the parity port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 SETTLE=1, DESC=0, mux x=4'b1010, start pulse -> sel 0,1,2,3 on consecutive cycles; bit_out 0,1,0,1; done 5 cycles after start; word_out=4'b1010.
REQ-031 SETTLE=3, DESC=1, x=4'b0110 -> sel 3,2,1,0, each held 3 cycles; done at cycle 13; word_out=4'b0110.
REQ-032 Scan with x=4'b1111, then abort during the sel=2 hold -> IDLE next cycle; no done; word_out[1:0]=2'b11, word_out[3:2] unchanged.
REQ-033 start re-asserted every cycle during a scan -> exactly one done per 4*SETTLE+1 cycles; sel never jumps back.
REQ-034 rst at the sel=1 sampling edge -> all outputs 0 next cycle; no bit_valid; no done.
REQ-035 With MUX_SCAN_PARITY_EN defined, x=4'b0111 -> parity=1 with done; with x=4'b0011 -> parity=0.
